// File: rtl/rr_arbiter.sv
// Round-robin arbiter: registered one-hot grant held until release_i or
// watchdog expiry, with rotating priority and back-to-back reissue.
module rr_arbiter #(
  parameter int N        = 4,
  parameter int HOLD_MAX = 0,
  localparam int IDX_W   = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             release_i,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout
);

  localparam int CNT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (HOLD_MAX > 0) ? CNT_W'(HOLD_MAX - 1) : '0;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t             state_r;
  logic [N-1:0]       grant_r;
  logic [IDX_W-1:0]   idx_r;
  logic [IDX_W-1:0]   ptr_r;
  logic               valid_r;
  logic               timeout_r;
  logic [CNT_W-1:0]   cnt_r;

  logic [IDX_W-1:0]   winner_s;
  logic [IDX_W-1:0]   ptr_next_s;
  logic [IDX_W-1:0]   pos_s;
  logic [IDX_W:0]     sum_s;
  logic               found_s;
  logic               expire_s;
  logic               end_s;

  function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot = {{(N-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Search ptr, ptr+1, ... (mod N); the first set request wins.
  always_comb begin
    winner_s = '0;
    found_s  = 1'b0;
    sum_s    = '0;
    pos_s    = '0;
    for (int k = 0; k < N; k++) begin
      sum_s = {1'b0, ptr_r} + (IDX_W+1)'(k);
      if (sum_s >= (IDX_W+1)'(N)) begin
        sum_s = sum_s - (IDX_W+1)'(N);
      end else begin
        sum_s = sum_s;
      end
      pos_s = sum_s[IDX_W-1:0];
      if (!found_s && req[pos_s]) begin
        found_s  = 1'b1;
        winner_s = pos_s;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Next pointer, watchdog expiry and end-of-grant detection.
  always_comb begin
    ptr_next_s = '0;
    if (winner_s == IDX_W'(N - 1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = winner_s + IDX_W'(1);
    end
    expire_s = (HOLD_MAX > 0) && (cnt_r == CNT_LAST);
    end_s    = (state_r == BUSY) && (release_i || expire_s);
  end

  // Grant FSM; all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      grant_r   <= '0;
      idx_r     <= '0;
      valid_r   <= 1'b0;
      timeout_r <= 1'b0;
      cnt_r     <= '0;
      ptr_r     <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          timeout_r <= 1'b0;
          cnt_r     <= '0;
          if (found_s) begin
            state_r <= BUSY;
            grant_r <= onehot(winner_s);
            idx_r   <= winner_s;
            valid_r <= 1'b1;
            ptr_r   <= ptr_next_s;
          end else begin
            grant_r <= '0;
            idx_r   <= '0;
            valid_r <= 1'b0;
          end
        end
        BUSY: begin
          if (end_s) begin
            // A coincident release takes precedence: no timeout pulse.
            timeout_r <= expire_s && !release_i;
            cnt_r     <= '0;
            if (found_s) begin
              grant_r <= onehot(winner_s);
              idx_r   <= winner_s;
              valid_r <= 1'b1;
              ptr_r   <= ptr_next_s;
            end else begin
              state_r <= IDLE;
              grant_r <= '0;
              idx_r   <= '0;
              valid_r <= 1'b0;
            end
          end else begin
            timeout_r <= 1'b0;
            if (HOLD_MAX > 0) begin
              cnt_r <= cnt_r + CNT_W'(1);
            end else begin
              cnt_r <= cnt_r;
            end
          end
        end
        default: begin
          state_r   <= IDLE;
          grant_r   <= '0;
          idx_r     <= '0;
          valid_r   <= 1'b0;
          timeout_r <= 1'b0;
          cnt_r     <= '0;
        end
      endcase
    end
  end

  assign grant       = grant_r;
  assign grant_idx   = idx_r;
  assign grant_valid = valid_r;
  assign timeout     = timeout_r;

endmodule

// Protocol checker for rr_arbiter outputs; instantiated alongside the arbiter.
module rr_arbiter_chk #(
  parameter int N      = 4,
  localparam int IDX_W = $clog2(N)
) (
  input logic             clk,
  input logic             rst_n,
  input logic [N-1:0]     grant,
  input logic [IDX_W-1:0] grant_idx,
  input logic             grant_valid,
  input logic             timeout
);

  a_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));
  a_valid:   assert property (@(posedge clk) disable iff (!rst_n) grant_valid == (|grant));
  a_idx:     assert property (@(posedge clk) disable iff (!rst_n) grant_valid |-> grant[grant_idx]);
  a_timeout: assert property (@(posedge clk) disable iff (!rst_n) timeout |-> $past(grant_valid));

endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench for rr_arbiter (N=4, HOLD_MAX=8): each step pushes the
// expected {grant, grant_idx, grant_valid, timeout} and pops it after the edge.
module tb_rr_arbiter;

  localparam int N  = 4;
  localparam int HM = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       release_i;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_valid;
  logic       timeout;
  logic [7:0] obs;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  rr_arbiter #(.N(N), .HOLD_MAX(HM)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .release_i(release_i),
    .grant(grant), .grant_idx(grant_idx), .grant_valid(grant_valid), .timeout(timeout)
  );

  rr_arbiter_chk #(.N(N)) chk (
    .clk(clk), .rst_n(rst_n), .grant(grant), .grant_idx(grant_idx),
    .grant_valid(grant_valid), .timeout(timeout)
  );

  assign obs = {grant, grant_idx, grant_valid, timeout};

  function automatic logic [7:0] mk(input logic [3:0] g, input logic [1:0] i,
                                    input logic v, input logic t);
    return {g, i, v, t};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; req = 4'b0000; release_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] e;
    @(posedge clk); #1;
    checks++;
    if (obs !== 8'h00) begin errors++; $display("FAIL reset_held: got %b want %b", obs, 8'h00); end
    rst_n = 1'b1;
    req = 4'b0000; release_i = 1'b0;
    exp_q.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b0));
    @(posedge clk); #1;
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_idle: got %b want %b", obs, e); end
  endtask

  task automatic test_single_hold();
    logic [3:0] rq [7];
    logic       rl [7];
    logic [7:0] ex [7];
    logic [7:0] e;
    rq = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    rl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) ex[i] = mk(4'b0100, 2'd2, 1'b1, 1'b0);
    ex[6] = mk(4'b0000, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      req = rq[i]; release_i = rl[i]; exp_q.push_back(ex[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL single_hold step %0d: got %b want %b", i, obs, e); end
    end
  endtask

  task automatic test_rotate();
    logic       rl [6];
    logic [7:0] ex [6];
    logic [7:0] e;
    do_reset();
    rl = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    ex = '{mk(4'b0001, 2'd0, 1'b1, 1'b0), mk(4'b0010, 2'd1, 1'b1, 1'b0),
           mk(4'b0100, 2'd2, 1'b1, 1'b0), mk(4'b1000, 2'd3, 1'b1, 1'b0),
           mk(4'b0001, 2'd0, 1'b1, 1'b0), mk(4'b0000, 2'd0, 1'b0, 1'b0)};
    for (int i = 0; i < 6; i++) begin
      req = (i == 5) ? 4'b0000 : 4'b1111; release_i = rl[i]; exp_q.push_back(ex[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL rotate step %0d: got %b want %b", i, obs, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic       rl [6];
    logic [7:0] e;
    rl = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      req = (i == 5) ? 4'b0000 : 4'b0010; release_i = rl[i];
      exp_q.push_back((i == 5) ? mk(4'b0000, 2'd0, 1'b0, 1'b0) : mk(4'b0010, 2'd1, 1'b1, 1'b0));
      @(posedge clk); #1;
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL back_to_back step %0d: got %b want %b", i, obs, e); end
    end
  endtask

  task automatic test_watchdog();
    logic [3:0] rq [20];
    logic [7:0] ex [20];
    logic [7:0] e;
    // Part A: sole requester drops req, watchdog clears the grant.
    rq[0] = 4'b0001; ex[0] = mk(4'b0001, 2'd0, 1'b1, 1'b0);
    for (int i = 1; i < 8; i++) begin rq[i] = 4'b0000; ex[i] = mk(4'b0001, 2'd0, 1'b1, 1'b0); end
    rq[8] = 4'b0000; ex[8] = mk(4'b0000, 2'd0, 1'b0, 1'b1);
    rq[9] = 4'b0000; ex[9] = mk(4'b0000, 2'd0, 1'b0, 1'b0);
    // Part B: expiry hands the grant on to req[3].
    rq[10] = 4'b0001; ex[10] = mk(4'b0001, 2'd0, 1'b1, 1'b0);
    for (int i = 11; i < 18; i++) begin rq[i] = 4'b1001; ex[i] = mk(4'b0001, 2'd0, 1'b1, 1'b0); end
    rq[18] = 4'b1001; ex[18] = mk(4'b1000, 2'd3, 1'b1, 1'b1);
    rq[19] = 4'b1000; ex[19] = mk(4'b1000, 2'd3, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      req = rq[i]; release_i = 1'b0; exp_q.push_back(ex[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL watchdog step %0d: got %b want %b", i, obs, e); end
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] e;
    rst_n = 1'b0;
    #2;
    checks++;
    if (obs !== 8'h00) begin errors++; $display("FAIL async_reset_drop: got %b want %b", obs, 8'h00); end
    req = 4'b1010; release_i = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (obs !== 8'h00) begin errors++; $display("FAIL async_reset_hold: got %b want %b", obs, 8'h00); end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req = (i == 0) ? 4'b1010 : 4'b0000; release_i = (i == 1);
      exp_q.push_back((i == 0) ? mk(4'b0010, 2'd1, 1'b1, 1'b0) : mk(4'b0000, 2'd0, 1'b0, 1'b0));
      @(posedge clk); #1;
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL async_reset step %0d: got %b want %b", i, obs, e); end
    end
  endtask

  task automatic test_coincide();
    logic [7:0] e;
    for (int i = 0; i < 9; i++) begin
      req = (i == 0) ? 4'b0100 : 4'b0000; release_i = (i == 8);
      exp_q.push_back((i == 8) ? mk(4'b0000, 2'd0, 1'b0, 1'b0) : mk(4'b0100, 2'd2, 1'b1, 1'b0));
      @(posedge clk); #1;
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL coincide step %0d: got %b want %b", i, obs, e); end
    end
  endtask

  task automatic test_idle_release();
    logic [3:0] rq [5];
    logic       rl [5];
    logic [7:0] ex [5];
    logic [7:0] e;
    do_reset();
    rq = '{4'b0000, 4'b0000, 4'b0011, 4'b0011, 4'b0000};
    rl = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    ex = '{mk(4'b0000, 2'd0, 1'b0, 1'b0), mk(4'b0000, 2'd0, 1'b0, 1'b0),
           mk(4'b0001, 2'd0, 1'b1, 1'b0), mk(4'b0010, 2'd1, 1'b1, 1'b0),
           mk(4'b0000, 2'd0, 1'b0, 1'b0)};
    for (int i = 0; i < 5; i++) begin
      req = rq[i]; release_i = rl[i]; exp_q.push_back(ex[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL idle_release step %0d: got %b want %b", i, obs, e); end
    end
  endtask

  initial begin
    rst_n = 1'b0; req = 4'b0000; release_i = 1'b0;
    test_reset();
    test_single_hold();
    test_rotate();
    test_back_to_back();
    test_watchdog();
    test_async_reset();
    test_coincide();
    test_idle_release();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
- Round-robin arbiter that sits upstream of the encoder/decoder helpers in the NPU support library.
- Accepts N request lines from compute/DMA clients and issues a registered one-hot grant, plus its encoded index, to a shared resource such as an SRAM port or bus.
- Holds each grant until the resource signals release, with an optional watchdog that forces release.
- Rotating priority prevents starvation.

Parameters:
- N, 4, number of requesters; legal range 2..32.
- HOLD_MAX, 0, maximum cycles a grant may be held before forced release; 0 disables the watchdog.
- IDX_W, $clog2(N), width of grant_idx; derived from N, never overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- req  input  N  request vector; requester i holds req[i] high until it is granted.
- release_i  input  1  single-cycle pulse from the resource ending the current grant; ignored when no grant is active.
- grant  output  N  registered one-hot grant; all-zero when idle.
- grant_idx  output  IDX_W  binary index of the granted requester; 0 when idle.
- grant_valid  output  1  high while any grant is active; equals |grant.
- timeout  output  1  one-cycle pulse when the watchdog forces release.

Behaviour:
- Reset (asynchronous, rst_n low):
  - grant=0, grant_idx=0, grant_valid=0, timeout=0.
  - state=IDLE, hold counter=0, priority pointer ptr=0.
  - Reset mid-grant drops the grant immediately and does not wait for release.
- States:
  - IDLE → BUSY: in IDLE with |req=1, register the winner; grant is visible the next cycle (1-cycle latency).
  - BUSY, hold: grant, grant_idx and the winner stay stable regardless of req, including when the winner deasserts req.
  - BUSY, end of grant: release_i=1, or a watchdog expiry, ends the grant.
  - BUSY, back-to-back: if the req vector sampled that same cycle, after masking, is nonzero, the new winner's grant replaces the old one on the next edge (no idle bubble) and the state stays BUSY.
  - BUSY → IDLE: if the masked req vector is zero, grant clears next edge and the state returns to IDLE.
- Arbitration:
  - Search order is ptr, ptr+1, …, N-1, 0, …, ptr-1 (mod N); the first set req bit wins.
  - On every new grant, ptr ← (winner+1) mod N.
  - The previous winner is searched last, so it wins again only when it is the sole requester.
- Grant encoding: grant_idx always equals the index of the single set bit in grant. At most one grant bit is ever set.
- Watchdog:
  - Hold counter clears on every new grant and increments each BUSY cycle.
  - If HOLD_MAX>0 and the counter reaches HOLD_MAX-1 with no release, treat that cycle as a release: timeout=1 for that one cycle and re-arbitration proceeds exactly as for release_i.
  - If release_i and expiry coincide, it is a normal release and timeout stays 0.
  - With HOLD_MAX=0 the counter is inert and timeout stays 0.
- Ignored inputs: release_i in IDLE is ignored. req bits that toggle while BUSY affect only the next arbitration.
- Assertions:
  - grant is one-hot or zero (onehot0).
  - grant_valid == |grant.
  - timeout implies grant_valid was high in the previous cycle.

Test Plan:
- Reset, then req=4'b0100 → next cycle grant=4'b0100, grant_idx=2, grant_valid=1, ptr=3; grant stays stable 5 cycles with release_i=0 while req drops to 0.
- req=4'b1111 held, release_i pulsed each grant, starting ptr=0 → grant_idx sequence 0,1,2,3,0 with no idle cycles between grants.
- Only req[1] asserted and release pulsed repeatedly → grant_idx=1 every time; between grants grant stays 4'b0010 continuously (back-to-back reissue).
- HOLD_MAX=8, req=4'b0001, no release → timeout pulses exactly 8 cycles after grant rises; grant then clears, or moves to req[3] if req=4'b1001.
- rst_n asserted low mid-grant (grant=4'b1000) → grant=0 and grant_valid=0 asynchronously; after release of reset with req=4'b1010 → grant_idx=1 (ptr reset to 0).
- release_i pulsed in IDLE with req=0 → no grant, ptr unchanged; then req=4'b0011 → grant_idx=0.
